fixed_divider_seq: RTL and testbench

Parametrised sequential fixed-point divider for the Kalman-filter datapath. It computes quotients such as the gain term P/(P+R) without a vendor floating-point core. It accepts one signed or unsigned Qm.FRAC operand pair through a valid/ready handshake and computes the quotient bit-serially (one quotient bit per clock). It presents a saturated result with divide-by-zero and overflow flags, held until the consumer takes it.

---
 rtl/kf_div_pkg.sv | 32 +++
 rtl/fixed_divider_seq.sv | 147 ++++++++++++++
 tb/tb_fixed_divider_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/kf_div_pkg.sv
// Shared types and constant helpers for the Kalman-filter fixed-point divider.
// Limit helpers return 128-bit values so callers can size them to any operand width.
package kf_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFinish,
    StDone
  } div_state_e;

  localparam int unsigned LimW = 128;

  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned frac);
    return $clog2(width + frac + 1);
  endfunction

  // Largest representable positive magnitude.
  function automatic logic [LimW-1:0] pos_limit(input int unsigned width, input bit is_signed);
    logic [LimW-1:0] one;
    one = LimW'(1);
    return is_signed ? (one << (width - 1)) - one : (one << width) - one;
  endfunction

  // Largest representable negative magnitude; zero when results are unsigned.
  function automatic logic [LimW-1:0] neg_limit(input int unsigned width, input bit is_signed);
    logic [LimW-1:0] one;
    one = LimW'(1);
    return is_signed ? (one << (width - 1)) : '0;
  endfunction

endpackage

// File: rtl/fixed_divider_seq.sv
// Bit-serial restoring fixed-point divider: one quotient bit per clock, then saturate
// and sign the result, which is held until the consumer takes it.
module fixed_divider_seq
  import kf_div_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned SIGNED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned N        = WIDTH + FRAC;
  localparam int unsigned CntW     = cnt_width(WIDTH, FRAC);
  localparam bit          IsSigned = (SIGNED != 0);

  localparam logic [N-1:0]     LimPos  = N'(pos_limit(WIDTH, IsSigned));
  localparam logic [N-1:0]     LimNeg  = N'(neg_limit(WIDTH, IsSigned));
  localparam logic [WIDTH-1:0] ResMax  = WIDTH'(pos_limit(WIDTH, IsSigned));
  localparam logic [WIDTH-1:0] ResMin  = WIDTH'(neg_limit(WIDTH, IsSigned));
  localparam logic [CntW-1:0]  LastCnt = CntW'(N - 1);

  div_state_e r_state;
  div_state_e w_state_d;

  logic [N-1:0]     r_quo;
  logic [WIDTH-1:0] r_b_mag;
  logic [WIDTH:0]   r_rem;
  logic [CntW-1:0]  r_cnt;
  logic             r_sign;
  logic [WIDTH-1:0] r_result;
  logic             r_dbz;
  logic             r_ovf;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_b_ext;
  logic             w_ge;
  logic [WIDTH:0]   w_rem_nx;
  logic [WIDTH-1:0] w_q_lo;
  logic [WIDTH-1:0] w_res;
  logic             w_fin_dbz;
  logic             w_fin_ovf;

  assign in_ready     = (r_state == StIdle) && !reset;
  assign result_valid = (r_state == StDone);
  assign result       = r_result;
  assign div_by_zero  = r_dbz;
  assign overflow     = r_ovf;

  assign w_accept = in_valid && in_ready;
  assign w_a_neg  = IsSigned && dataa[WIDTH-1];
  assign w_b_neg  = IsSigned && datab[WIDTH-1];
  // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
  assign w_a_mag  = w_a_neg ? -dataa : dataa;
  assign w_b_mag  = w_b_neg ? -datab : datab;

  // r_quo starts as the scaled dividend; its bits shift out MSB-first as quotient bits shift in.
  assign w_rem_sh = {r_rem[WIDTH-1:0], r_quo[N-1]};
  assign w_b_ext  = {1'b0, r_b_mag};
  assign w_ge     = (w_rem_sh >= w_b_ext);
  assign w_rem_nx = w_ge ? (w_rem_sh - w_b_ext) : w_rem_sh;
  assign w_q_lo   = r_quo[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_d = (datab == '0) ? StFinish : StCalc;
      StCalc:   if (r_cnt == LastCnt) w_state_d = StFinish;
      StFinish: w_state_d = StDone;
      StDone:   if (result_ready) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // With a zero divisor r_quo still holds the scaled dividend, and r_sign is the sign of dataa.
  always_comb begin
    w_res     = '0;
    w_fin_dbz = 1'b0;
    w_fin_ovf = 1'b0;
    if (r_b_mag == '0) begin
      w_fin_dbz = 1'b1;
      if (r_quo != '0) w_res = r_sign ? ResMin : ResMax;
    end else if (r_quo > (r_sign ? LimNeg : LimPos)) begin
      w_fin_ovf = 1'b1;
      w_res     = r_sign ? ResMin : ResMax;
    end else begin
      w_res = r_sign ? -w_q_lo : w_q_lo;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_quo    <= '0;
      r_b_mag  <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_quo   <= N'(w_a_mag) << FRAC;
        r_b_mag <= w_b_mag;
        r_sign  <= w_a_neg ^ w_b_neg;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_dbz   <= 1'b0;
        r_ovf   <= 1'b0;
      end
      if (r_state == StCalc) begin
        r_rem <= w_rem_nx;
        r_quo <= {r_quo[N-2:0], w_ge};
        r_cnt <= r_cnt + CntW'(1);
      end
      if (r_state == StFinish) begin
        r_result <= w_res;
        r_dbz    <= w_fin_dbz;
        r_ovf    <= w_fin_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_divider_seq.sv
// Self-checking bench for fixed_divider_seq at default parameters: directed vectors,
// backpressure, mid-operation reset and randomized operands against an arithmetic model.
module tb_fixed_divider_seq;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] dataa = '0;
  logic [W-1:0] datab = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] result;
  logic         result_valid;
  logic         result_ready = 1'b1;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_res;
  logic         last_dbz;
  logic         last_ovf;

  fixed_divider_seq #(
    .WIDTH (32),
    .FRAC  (16),
    .SIGNED(1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dataa       (dataa),
    .datab       (datab),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Q16.16 signed division using plain integer arithmetic (truncates toward zero).
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic dbz, output logic ovf);
    longint sa, sb, q, lmax, lmin;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    lmax = 64'sd2147483647;
    lmin = -64'sd2147483648;
    dbz  = 1'b0;
    ovf  = 1'b0;
    if (b == '0) begin
      dbz = 1'b1;
      if (a == '0) r = '0;
      else r = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      q = (sa * 65536) / sb;
      if (q > lmax) begin
        ovf = 1'b1;
        r   = 32'h7FFF_FFFF;
      end else if (q < lmin) begin
        ovf = 1'b1;
        r   = 32'h8000_0000;
      end else begin
        r = 32'(q);
      end
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] er;
    logic         ed;
    logic         eo;
    int           lat;
    ref_div(a, b, er, ed, eo);
    @(negedge clock);
    chk({tag, " in_ready before accept"}, 64'(in_ready), 64'd1);
    dataa    = a;
    datab    = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    dataa    = $urandom;
    datab    = $urandom;
    lat      = 0;
    while (!result_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), (b == '0) ? 64'd1 : 64'd49);
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
    chk({tag, " overflow"}, 64'(overflow), 64'(eo));
    last_res = result;
    last_dbz = div_by_zero;
    last_ovf = overflow;
    if (result_ready) begin
      @(posedge clock);
      #1;
      chk({tag, " valid drops"}, 64'(result_valid), 64'd0);
      chk({tag, " idle after done"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #1;
    chk("reset result", 64'(result), 64'd0);
    chk("reset result_valid", 64'(result_valid), 64'd0);
    chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("in_ready after reset", 64'(in_ready), 64'd1);

    run_op(32'h0006_0000, 32'h0002_0000, "6/2");
    chk("6/2 const", 64'(last_res), 64'h0003_0000);
    run_op(32'hFFF8_8000, 32'h0002_0000, "-7.5/2");
    chk("-7.5/2 const", 64'(last_res), 64'hFFFC_4000);
    run_op(32'h0001_0000, 32'h0003_0000, "1/3");
    chk("1/3 const", 64'(last_res), 64'h0000_5555);
    run_op(32'h0005_0000, 32'h0000_0000, "5/0");
    chk("5/0 const", 64'(last_res), 64'h7FFF_FFFF);
    chk("5/0 dbz const", 64'(last_dbz), 64'd1);
    run_op(32'hFFFB_0000, 32'h0000_0000, "-5/0");
    chk("-5/0 const", 64'(last_res), 64'h8000_0000);
    run_op(32'h0000_0000, 32'h0000_0000, "0/0");
    chk("0/0 const", 64'(last_res), 64'h0);
    run_op(32'h7FFF_0000, 32'h0000_0100, "big/small");
    chk("big/small const", 64'(last_res), 64'h7FFF_FFFF);
    chk("big/small ovf const", 64'(last_ovf), 64'd1);
    run_op(32'h8000_0000, 32'h0001_0000, "min/1");
    chk("min/1 const", 64'(last_res), 64'h8000_0000);
    chk("min/1 ovf const", 64'(last_ovf), 64'd0);

    // Consumer stalls for 10 cycles; a new operand pair is offered and must be ignored.
    result_ready = 1'b0;
    run_op(32'h7FFF_0000, 32'h0000_0100, "bp");
    for (int i = 0; i < 10; i++) begin
      dataa    = 32'h0001_0000;
      datab    = 32'h0001_0000;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      chk("bp result hold", 64'(result), 64'(last_res));
      chk("bp valid hold", 64'(result_valid), 64'd1);
      chk("bp ovf hold", 64'(overflow), 64'(last_ovf));
      chk("bp in_ready low", 64'(in_ready), 64'd0);
    end
    in_valid     = 1'b0;
    result_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp release valid", 64'(result_valid), 64'd0);
    chk("bp release idle", 64'(in_ready), 64'd1);
    run_op(32'h0006_0000, 32'h0002_0000, "after bp");

    run_op(32'h7FFF_0000, 32'h0000_0100, "pre-reset");
    @(negedge clock);
    dataa    = 32'h0006_0000;
    datab    = 32'h0002_0000;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset result", 64'(result), 64'd0);
    chk("async reset valid", 64'(result_valid), 64'd0);
    chk("async reset dbz", 64'(div_by_zero), 64'd0);
    chk("async reset ovf", 64'(overflow), 64'd0);
    chk("async reset in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("in_ready after async reset", 64'(in_ready), 64'd1);
    repeat (60) @(posedge clock);
    #1;
    chk("discarded op stays idle", 64'(result_valid), 64'd0);
    run_op(32'h0006_0000, 32'h0002_0000, "post-reset 6/2");
    chk("post-reset const", 64'(last_res), 64'h0003_0000);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      run_op(ra, rb, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
